// File: rtl/register_file_sb.sv
// Two-read / one-write register file with write-to-read bypass, optional hardwired
// zero register and a per-register pending-write scoreboard for hazard detection.
module register_file_sb #(
  parameter int N        = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_ena,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]      wr_data,
  input  logic              rsv_ena,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [N-1:0]      rd_data0,
  output logic [N-1:0]      rd_data1,
  output logic              busy0,
  output logic              busy1,
  output logic [ADDR_W:0]   busy_count
);

  localparam int   DEPTH    = 1 << ADDR_W;
  localparam logic HAS_ZERO = 1'(ZERO_REG != 0);

  logic [N-1:0]      regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [ADDR_W:0]   busy_count_q;

  logic wr_valid;
  logic rsv_valid;
  logic set_new;
  logic release_old;

  always_comb begin
    wr_valid    = wr_ena  && !(HAS_ZERO && (wr_addr  == '0));
    rsv_valid   = rsv_ena && !(HAS_ZERO && (rsv_addr == '0));
    set_new     = rsv_valid && !busy_q[rsv_addr];
    // A write to a busy register that is re-reserved in the same cycle keeps it busy.
    release_old = wr_valid && busy_q[wr_addr] && !(rsv_valid && (rsv_addr == wr_addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Reserve is applied after the release so that it wins on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      if (wr_valid) begin
        busy_q[wr_addr] <= 1'b0;
      end
      if (rsv_valid) begin
        busy_q[rsv_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_count_q <= '0;
    end else if (set_new && !release_old) begin
      busy_count_q <= busy_count_q + (ADDR_W+1)'(1);
    end else if (release_old && !set_new) begin
      busy_count_q <= busy_count_q - (ADDR_W+1)'(1);
    end
  end

  assign busy_count = busy_count_q;

  logic [ADDR_W-1:0] rd_addr_k [2];
  logic [N-1:0]      rd_data_k [2];
  logic              rd_busy_k [2];

  assign rd_addr_k[0] = rd_addr0;
  assign rd_addr_k[1] = rd_addr1;

  // Bypass is suppressed while reset is asserted so the outputs read as zero.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rd_data_k[k] = regs[rd_addr_k[k]];
      rd_busy_k[k] = busy_q[rd_addr_k[k]];
      if (HAS_ZERO && (rd_addr_k[k] == '0)) begin
        rd_data_k[k] = '0;
        rd_busy_k[k] = 1'b0;
      end else if (rst_n && wr_ena && (wr_addr == rd_addr_k[k])) begin
        rd_data_k[k] = wr_data;
        rd_busy_k[k] = 1'b0;
      end
    end
  end

  assign rd_data0 = rd_data_k[0];
  assign rd_data1 = rd_data_k[1];
  assign busy0    = rd_busy_k[0];
  assign busy1    = rd_busy_k[1];

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: a behavioural model produces expected
// read-port values that are queued at drive time and compared at the sample point.
module tb_register_file_sb;

  logic        clk;
  logic        rst_n;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_ena;
  logic [4:0]  rsv_addr;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [31:0] rd_data0;
  logic [31:0] rd_data1;
  logic        busy0;
  logic        busy1;
  logic [5:0]  busy_count;

  int checks   = 0;
  int failures = 0;

  typedef logic [71:0] obs_t;
  obs_t sb [$];
  obs_t exp_v;
  obs_t obs_v;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  a0;
    logic [4:0]  a1;
  } step_t;

  register_file_sb #(.N(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_ena     (wr_ena),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_ena    (rsv_ena),
    .rsv_addr   (rsv_addr),
    .rd_addr0   (rd_addr0),
    .rd_addr1   (rd_addr1),
    .rd_data0   (rd_data0),
    .rd_data1   (rd_data1),
    .busy0      (busy0),
    .busy1      (busy1),
    .busy_count (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit [31:0] m_regs [32];
  bit [31:0] m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else begin
      if (wr_ena && wr_addr != 5'd0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (rsv_ena && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    end
  end

  function automatic logic [32:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 33'd0;
    if (rst_n && wr_ena && wr_addr == a) return {1'b0, wr_data};
    return {m_busy[a], m_regs[a]};
  endfunction

  function automatic void push_expected();
    logic [32:0] e0;
    logic [32:0] e1;
    e0 = m_read(rd_addr0);
    e1 = m_read(rd_addr1);
    sb.push_back({e0[31:0], e1[31:0], e0[32], e1[32], 6'($countones(m_busy))});
  endfunction

  task automatic drive(input step_t s);
    @(posedge clk);
    #1;
    wr_ena   = s.we;
    wr_addr  = s.wa;
    wr_data  = s.wd;
    rsv_ena  = s.re;
    rsv_addr = s.ra;
    rd_addr0 = s.a0;
    rd_addr1 = s.a1;
    push_expected();
  endtask

  task automatic test_reset();
    rd_addr0 = 5'd0;
    rd_addr1 = 5'd1;
    repeat (2) @(negedge clk);
    push_expected();
    exp_v = sb.pop_front();
    obs_v = {rd_data0, rd_data1, busy0, busy1, busy_count};
    checks++;
    if (obs_v !== exp_v || obs_v !== 72'd0) begin
      failures++;
      $display("FAIL reset_held: got %h want %h", obs_v, 72'd0);
    end
    rst_n = 1'b1;
    drive('{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd1});
    @(negedge clk);
    exp_v = sb.pop_front();
    obs_v = {rd_data0, rd_data1, busy0, busy1, busy_count};
    checks++;
    if (obs_v !== exp_v || obs_v !== 72'd0) begin
      failures++;
      $display("FAIL reset_released: got %h want %h", obs_v, 72'd0);
    end
  endtask

  task automatic test_write_read();
    step_t st [2] = '{
      '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd5},
      '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd5, 5'd1}
    };
    for (int i = 0; i < 2; i++) begin
      drive(st[i]);
      @(negedge clk);
      exp_v = sb.pop_front();
      obs_v = {rd_data0, rd_data1, busy0, busy1, busy_count};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL write_read step%0d: got %h want %h", i, obs_v, exp_v);
      end
      checks++;
      if ((i == 0 ? rd_data1 : rd_data0) !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL write_read_value step%0d: got %h want deadbeef", i, (i == 0 ? rd_data1 : rd_data0));
      end
    end
  endtask

  task automatic test_zero_reg();
    step_t st [3] = '{
      '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0},
      '{1'b0, 5'd0, 32'd0,        1'b1, 5'd0, 5'd0, 5'd0},
      '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd0, 5'd5}
    };
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      @(negedge clk);
      exp_v = sb.pop_front();
      obs_v = {rd_data0, rd_data1, busy0, busy1, busy_count};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL zero_reg step%0d: got %h want %h", i, obs_v, exp_v);
      end
      if (i == 2) begin
        checks++;
        if ({rd_data0, busy0, busy_count} !== 39'd0) begin
          failures++;
          $display("FAIL zero_reg_final: got data=%h busy=%b count=%0d want 0/0/0", rd_data0, busy0, busy_count);
        end
      end
    end
  endtask

  task automatic test_scoreboard();
    step_t st [6] = '{
      '{1'b0, 5'd0, 32'd0,    1'b1, 5'd7, 5'd7, 5'd9},
      '{1'b0, 5'd0, 32'd0,    1'b1, 5'd9, 5'd7, 5'd9},
      '{1'b1, 5'd7, 32'h12,   1'b0, 5'd0, 5'd7, 5'd9},
      '{1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd7, 5'd9},
      '{1'b0, 5'd0, 32'd0,    1'b1, 5'd9, 5'd9, 5'd9},
      '{1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd9, 5'd7}
    };
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      @(negedge clk);
      exp_v = sb.pop_front();
      obs_v = {rd_data0, rd_data1, busy0, busy1, busy_count};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL scoreboard step%0d: got %h want %h", i, obs_v, exp_v);
      end
      if (i == 1) begin
        checks++;
        if ({busy0, busy_count} !== {1'b1, 6'd1}) begin
          failures++;
          $display("FAIL sb_reserve_x7: got busy0=%b count=%0d want 1/1", busy0, busy_count);
        end
      end
      if (i == 2) begin
        checks++;
        if ({busy0, rd_data0, busy_count} !== {1'b0, 32'h12, 6'd2}) begin
          failures++;
          $display("FAIL sb_release_bypass: got busy0=%b data=%h count=%0d want 0/12/2", busy0, rd_data0, busy_count);
        end
      end
      if (i == 3 || i == 5) begin
        checks++;
        if (busy_count !== 6'd1) begin
          failures++;
          $display("FAIL sb_count step%0d: got %0d want 1", i, busy_count);
        end
      end
    end
  endtask

  task automatic test_collision();
    step_t st [3] = '{
      '{1'b0, 5'd0, 32'd0,  1'b1, 5'd3, 5'd3, 5'd3},
      '{1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 5'd3, 5'd3},
      '{1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 5'd3, 5'd3}
    };
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      @(negedge clk);
      exp_v = sb.pop_front();
      obs_v = {rd_data0, rd_data1, busy0, busy1, busy_count};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL collision step%0d: got %h want %h", i, obs_v, exp_v);
      end
      if (i == 2) begin
        checks++;
        if (obs_v !== {32'h55, 32'h55, 1'b1, 1'b1, 6'd2}) begin
          failures++;
          $display("FAIL collision_final: got %h want %h", obs_v, {32'h55, 32'h55, 1'b1, 1'b1, 6'd2});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    for (int i = 0; i < 60; i++) begin
      s.we = 1'($urandom_range(0, 1));
      s.wa = 5'($urandom_range(0, 7));
      s.wd = $urandom;
      s.re = 1'($urandom_range(0, 1));
      s.ra = 5'($urandom_range(0, 7));
      s.a0 = 5'($urandom_range(0, 7));
      s.a1 = ($urandom_range(0, 3) == 0) ? s.a0 : 5'($urandom_range(0, 7));
      drive(s);
      @(negedge clk);
      exp_v = sb.pop_front();
      obs_v = {rd_data0, rd_data1, busy0, busy1, busy_count};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL back_to_back step%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset();
    step_t st [4] = '{
      '{1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd4, 5'd6},
      '{1'b0, 5'd0, 32'd0,        1'b1, 5'd4, 5'd4, 5'd6},
      '{1'b0, 5'd0, 32'd0,        1'b1, 5'd6, 5'd4, 5'd6},
      '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd4, 5'd6}
    };
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      @(negedge clk);
      exp_v = sb.pop_front();
      obs_v = {rd_data0, rd_data1, busy0, busy1, busy_count};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL mid_reset_setup step%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    push_expected();
    exp_v = sb.pop_front();
    obs_v = {rd_data0, rd_data1, busy0, busy1, busy_count};
    checks++;
    if (obs_v !== exp_v || obs_v !== 72'd0) begin
      failures++;
      $display("FAIL mid_reset_async: got %h want %h", obs_v, 72'd0);
    end
    #1 rst_n = 1'b1;
    drive('{1'b1, 5'd2, 32'h0BADF00D, 1'b1, 5'd6, 5'd2, 5'd6});
    @(negedge clk);
    exp_v = sb.pop_front();
    obs_v = {rd_data0, rd_data1, busy0, busy1, busy_count};
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL post_reset_edge: got %h want %h", obs_v, exp_v);
    end
    drive('{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd2, 5'd6});
    @(negedge clk);
    exp_v = sb.pop_front();
    obs_v = {rd_data0, rd_data1, busy0, busy1, busy_count};
    checks++;
    if (obs_v !== exp_v || obs_v !== {32'h0BADF00D, 32'd0, 1'b0, 1'b1, 6'd1}) begin
      failures++;
      $display("FAIL post_reset_state: got %h want %h", obs_v, {32'h0BADF00D, 32'd0, 1'b0, 1'b1, 6'd1});
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_ena   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_ena  = 1'b0;
    rsv_addr = '0;
    rd_addr0 = '0;
    rd_addr1 = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
